// File: rtl/reversible_pkg.sv
// Shared types and constants for the reversible-gate inverse unit.
// Also holds the saturating counter increment used by the statistics counters.
package reversible_pkg;

  typedef enum logic [1:0] {
    MODE_FREDKIN = 2'd0,
    MODE_PERES   = 2'd1,
    MODE_ADD     = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v == {CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/rev_inv_slice.sv
// Combinational inverse of one SLICE-bit chunk of a Fredkin, Peres or A+B+1 gate.
// carry_out is only meaningful in adder mode and is zero otherwise.
module rev_inv_slice
  import reversible_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  mode_e            mode,
  input  logic [SLICE-1:0] p,
  input  logic [SLICE-1:0] q,
  input  logic [SLICE-1:0] r,
  input  logic             carry_in,
  output logic [SLICE-1:0] a,
  output logic [SLICE-1:0] b,
  output logic [SLICE-1:0] c,
  output logic             carry_out
);

  logic [SLICE:0] sum_s;

  // Per-mode inverse; the adder undoes Q = A + B + 1 as B = Q + ~A (+ carry).
  always_comb begin
    sum_s     = {1'b0, q} + {1'b0, ~p} + {{SLICE{1'b0}}, carry_in};
    a         = p;
    b         = {SLICE{1'b0}};
    c         = {SLICE{1'b0}};
    carry_out = 1'b0;
    case (mode)
      MODE_FREDKIN: begin
        b = (p & r) | (~p & q);
        c = (p & q) | (~p & r);
      end
      MODE_PERES: begin
        b = p ^ q;
        c = (p & (p ^ q)) ^ r;
      end
      MODE_ADD: begin
        b         = sum_s[SLICE-1:0];
        c         = r;
        carry_out = sum_s[SLICE];
      end
      default: begin
        a = {SLICE{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/reversible_inverse_unit.sv
// Bit-serial (SLICE bits per cycle, LSB first) decoder recovering A/B/C from
// reversible-gate outputs P/Q/R, with valid/ready on both sides and word/error counters.
module reversible_inverse_unit
  import reversible_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
  input  logic [WIDTH-1:0] in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [1:0]       out_mode,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_err,
  output logic             busy
);

  localparam int N     = WIDTH / SLICE;
  localparam int SCW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [SCW-1:0] LAST_SLICE = SCW'(N - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("WIDTH must be a multiple of SLICE");
  end

  state_e                 state_r;
  mode_e                  mode_r;
  logic [SCW-1:0]         slice_cnt_r;
  logic                   carry_r;
  logic [WIDTH-1:0]       p_sr_r, q_sr_r, r_sr_r;
  logic [WIDTH-1:0]       a_r, b_r, c_r;
  logic                   out_valid_r, out_err_r;
  logic [1:0]             out_mode_r;
  logic [CNT_W-1:0]       cnt_words_r, cnt_err_r;

  logic [SLICE-1:0]       slice_a_s, slice_b_s, slice_c_s;
  logic                   slice_carry_s;
  logic [WIDTH+SLICE-1:0] a_cat_s, b_cat_s, c_cat_s;

  rev_inv_slice #(.SLICE(SLICE)) u_slice (
    .mode      (mode_r),
    .p         (p_sr_r[SLICE-1:0]),
    .q         (q_sr_r[SLICE-1:0]),
    .r         (r_sr_r[SLICE-1:0]),
    .carry_in  (carry_r),
    .a         (slice_a_s),
    .b         (slice_b_s),
    .c         (slice_c_s),
    .carry_out (slice_carry_s)
  );

  // New slice enters from the MSB side so the word is LSB-aligned after N slices.
  always_comb begin
    a_cat_s = {slice_a_s, a_r} >> SLICE;
    b_cat_s = {slice_b_s, b_r} >> SLICE;
    c_cat_s = {slice_c_s, c_r} >> SLICE;
  end

  // Control FSM with datapath shift registers, carry chain and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mode_r      <= MODE_FREDKIN;
      slice_cnt_r <= {SCW{1'b0}};
      carry_r     <= 1'b0;
      p_sr_r      <= {WIDTH{1'b0}};
      q_sr_r      <= {WIDTH{1'b0}};
      r_sr_r      <= {WIDTH{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      c_r         <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
      out_mode_r  <= 2'd0;
      cnt_words_r <= {CNT_W{1'b0}};
      cnt_err_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            p_sr_r      <= in_p;
            q_sr_r      <= in_q;
            r_sr_r      <= in_r;
            mode_r      <= mode_e'(in_mode);
            slice_cnt_r <= {SCW{1'b0}};
            carry_r     <= 1'b0;
            state_r     <= RUN;
          end else begin
            state_r     <= IDLE;
          end
        end
        RUN: begin
          p_sr_r  <= p_sr_r >> SLICE;
          q_sr_r  <= q_sr_r >> SLICE;
          r_sr_r  <= r_sr_r >> SLICE;
          a_r     <= a_cat_s[WIDTH-1:0];
          b_r     <= b_cat_s[WIDTH-1:0];
          c_r     <= c_cat_s[WIDTH-1:0];
          carry_r <= slice_carry_s;
          if (slice_cnt_r == LAST_SLICE) begin
            state_r     <= HOLD;
            out_valid_r <= 1'b1;
            out_err_r   <= (mode_r == MODE_ILLEGAL);
            out_mode_r  <= mode_r;
          end else begin
            slice_cnt_r <= slice_cnt_r + {{(SCW-1){1'b0}}, 1'b1};
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
            cnt_words_r <= sat_inc(cnt_words_r);
            if (out_err_r) begin
              cnt_err_r <= sat_inc(cnt_err_r);
            end else begin
              cnt_err_r <= cnt_err_r;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_err   = out_err_r;
  assign out_mode  = out_mode_r;
  assign out_a     = a_r;
  assign out_b     = b_r;
  assign out_c     = c_r;
  assign cnt_words = cnt_words_r;
  assign cnt_err   = cnt_err_r;

endmodule

// File: tb/tb_reversible_inverse_unit.sv
// Self-checking bench: directed vector table, backpressure/reset sequences and
// randomized words checked against a word-level arithmetic model of the gate inverses.
module tb_reversible_inverse_unit;

  localparam int W = 32;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [W-1:0]  in_p, in_q, in_r;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_a, out_b, out_c;
  logic [1:0]    out_mode;
  logic          out_err;
  logic [15:0]   cnt_words, cnt_err;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_words = 0;
  int exp_errs  = 0;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] p, q, r;
    logic [W-1:0] a, b, c;
    logic         err;
  } vec_t;

  vec_t vecs[6];

  reversible_inverse_unit #(.WIDTH(W), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_p(in_p), .in_q(in_q), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_mode(out_mode),
    .out_err(out_err), .cnt_words(cnt_words), .cnt_err(cnt_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Whole-word inverse from the gate definitions
  task automatic ref_model(input logic [1:0] m, input logic [W-1:0] p, q, r,
                           output logic [W-1:0] a, b, c, output logic err);
    err = 1'b0;
    case (m)
      2'd0: begin a = p; b = (p & r) | (~p & q); c = (p & q) | (~p & r); end
      2'd1: begin a = p; b = p ^ q; c = (p & b) ^ r; end
      2'd2: begin a = p; b = q - p - 32'd1; c = r; end
      default: begin a = '0; b = '0; c = '0; err = 1'b1; end
    endcase
  endtask

  // Send one word, check latency and result, stall for 'stall' cycles, then drain.
  task automatic run_word(input logic [1:0] m, input logic [W-1:0] p, q, r,
                          input int stall, input string tag);
    logic [W-1:0] ea, eb, ec;
    logic ee;
    int cyc;
    ref_model(m, p, q, r, ea, eb, ec, ee);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_in_ready_wait"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_mode = m; in_p = p; in_q = q; in_r = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mode = 2'($urandom); in_p = $urandom; in_q = $urandom; in_r = $urandom;
    chk({tag, "_accepted"}, {30'd0, busy, in_ready}, 32'd2);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!out_valid && cyc < 20);
    chk({tag, "_latency"}, cyc, N);
    chk({tag, "_a"}, out_a, ea);
    chk({tag, "_b"}, out_b, eb);
    chk({tag, "_c"}, out_c, ec);
    chk({tag, "_err_mode"}, {29'd0, out_err, out_mode}, {29'd0, ee, m});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_ctrl"}, {29'd0, out_valid, in_ready, busy}, 32'd5);
      chk({tag, "_stall_data"}, out_a ^ out_b ^ out_c ^ {31'd0, out_err}, ea ^ eb ^ ec ^ {31'd0, ee});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_words++;
    if (ee) exp_errs++;
    chk({tag, "_drained"}, {30'd0, out_valid, in_ready}, 32'd1);
    chk({tag, "_cnt_words"}, {16'd0, cnt_words}, exp_words);
    chk({tag, "_cnt_err"}, {16'd0, cnt_err}, exp_errs);
  endtask

  initial begin
    vecs[0] = '{2'd1, 32'h12345678, 32'h88888888, 32'h95511551, 32'h12345678, 32'h9ABCDEF0, 32'h87654321, 1'b0};
    vecs[1] = '{2'd0, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b0};
    vecs[2] = '{2'd2, 32'h00000001, 32'h00000000, 32'hCAFEF00D, 32'h00000001, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b0};
    vecs[3] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0BADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0BADBEEF, 1'b0};
    vecs[4] = '{2'd3, 32'hDEADBEEF, 32'h13572468, 32'hFEDCBA98, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
    vecs[5] = '{2'd0, 32'hF0F0F0F0, 32'h12345678, 32'h9ABCDEF0, 32'hF0F0F0F0, 32'h92B4D6F8, 32'h1A3C5E70, 1'b0};

    in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0;
    in_p = '0; in_q = '0; in_r = '0;
    rst_n = 1'b0;
    #12;
    chk("reset_ctrl", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("reset_err_mode", {29'd0, out_err, out_mode}, 32'd0);
    chk("reset_cnts", {cnt_words, cnt_err}, 32'd0);
    chk("reset_outs", out_a | out_b | out_c, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table against fixed expectations
    for (int i = 0; i < 6; i++) begin
      int cyc;
      cyc = 0;
      in_valid = 1'b1; in_mode = vecs[i].mode;
      in_p = vecs[i].p; in_q = vecs[i].q; in_r = vecs[i].r;
      @(posedge clk); #1;
      in_valid = 1'b0;
      do begin
        @(posedge clk); #1; cyc++;
      end while (!out_valid && cyc < 20);
      chk($sformatf("vec%0d_latency", i), cyc, N);
      chk($sformatf("vec%0d_a", i), out_a, vecs[i].a);
      chk($sformatf("vec%0d_b", i), out_b, vecs[i].b);
      chk($sformatf("vec%0d_c", i), out_c, vecs[i].c);
      chk($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].err});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_words++;
      if (vecs[i].err) exp_errs++;
      chk($sformatf("vec%0d_cnt_words", i), {16'd0, cnt_words}, exp_words);
      chk($sformatf("vec%0d_cnt_err", i), {16'd0, cnt_err}, exp_errs);
    end

    // Backpressure for 5 cycles, then a back-to-back word
    run_word(2'd1, 32'h12345678, 32'h88888888, 32'h95511551, 5, "bp");
    run_word(2'd2, 32'h00000001, 32'h00000000, 32'h11112222, 0, "b2b");

    // Reset in the second RUN cycle
    in_valid = 1'b1; in_mode = 2'd2; in_p = 32'hFFFFFFFF; in_q = 32'h00000000; in_r = 32'h5A5A5A5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_ctrl", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("midrun_reset_cnts", {cnt_words, cnt_err}, 32'd0);
    chk("midrun_reset_outs", out_a | out_b | out_c, 32'd0);
    #2; rst_n = 1'b1;
    exp_words = 0; exp_errs = 0;
    @(posedge clk); #1;
    run_word(2'd1, 32'h12345678, 32'h88888888, 32'h95511551, 0, "post_reset");

    // Randomized words, including illegal mode and stalls
    for (int i = 0; i < 40; i++) begin
      run_word(2'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
               $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
